// File: rtl/disp_rdma_ctrl_if.sv
// AXI4 read-address / read-data signal bundle between the display reader
// and the HP read port. RDATA is not routed here; the FIFO takes it
// directly from the port.
//   araddr  burst start address
//   arlen   beats per burst minus one
//   arvalid / arready  address handshake
//   rvalid / rready    data handshake
//   rlast   last beat of a burst
//   rresp   read response, nonzero = error
// master: the controller side. slave: the memory/port side.
interface disp_rdma_ctrl_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rlast;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rvalid, rlast, rresp
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rvalid, rlast, rresp
  );
endinterface

// File: rtl/disp_rdma_ctrl.sv
// Display read-DMA controller: streams one frame from VRAM into the display
// FIFO as a sequence of fixed-length AXI read bursts. Each burst is issued
// only when the FIFO has room for it plus every burst already in flight.
//
// Ports
//   aclk       clock, rising edge
//   arst       synchronous reset, active-high
//   axi        AXI read address/data bundle (master side)
//   axistart   frame start strobe, asynchronous to aclk
//   dispon     display enable level; dropping it aborts the frame
//   dispaddr   frame base address, captured on start
//   fifofree   free FIFO entries, in beats
//   busy       frame transfer in progress
//   framedone  one-cycle pulse when a complete frame has drained
//   rerr       sticky: an error response was seen since the last start
//
// state | meaning
// HALT  | idle, waiting for a synchronised start edge
// CHECK | decide: finish/abort, or issue the next burst once space allows
// ISSUE | ARVALID up, address held until accepted
// DRAIN | no more issue; wait for all outstanding bursts to return
module disp_rdma_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BPP_BYTES   = 4,
  parameter int DATA_BYTES  = 8,
  parameter int BURST_BEATS = 16,
  parameter int MAX_OUTST   = 2,
  parameter int FREE_W      = 10
) (
  input  logic               aclk,
  input  logic               arst,
  disp_rdma_ctrl_if.master   axi,
  input  logic               axistart,
  input  logic               dispon,
  input  logic [29:0]        dispaddr,
  input  logic [FREE_W-1:0]  fifofree,
  output logic               busy,
  output logic               framedone,
  output logic               rerr
);

  localparam int BURST_BYTES = BURST_BEATS * DATA_BYTES;
  localparam int FRAME_BYTES = H_RES * V_RES * BPP_BYTES;

  localparam logic [29:0] BURST_OFS = 30'(BURST_BYTES);
  localparam logic [29:0] FRAME_OFS = 30'(FRAME_BYTES);
  localparam logic [3:0]  OUTST_MAX = 4'(MAX_OUTST);

  typedef enum logic [1:0] {
    HALT,
    CHECK,
    ISSUE,
    DRAIN
  } state_t;

  state_t      state;
  logic [2:0]  sync_q;
  logic [29:0] base;
  logic [29:0] offset;
  logic [3:0]  outst;

  logic        start;
  logic        ar_fire;
  logic        r_done;
  logic [31:0] space_need;
  logic        space_ok;

  // sync_q[1] is the newest synchronised sample, sync_q[2] the one before it
  assign start   = dispon & (sync_q[2:1] == 2'b01);
  assign ar_fire = axi.arvalid & axi.arready;
  // rready mirrors rvalid, so every valid beat is a completed transfer
  assign r_done  = axi.rvalid & axi.rlast;

  assign axi.arlen  = 8'(BURST_BEATS - 1);
  assign axi.rready = axi.rvalid;

  // Room must exist for this burst and all bursts still in flight.
  always_comb begin
    space_need = 32'(BURST_BEATS) * (32'(outst) + 32'd1);
    space_ok   = (outst < OUTST_MAX) && (32'(fifofree) >= space_need);
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state       <= HALT;
      sync_q      <= 3'b000;
      base        <= '0;
      offset      <= '0;
      outst       <= '0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      busy        <= 1'b0;
      framedone   <= 1'b0;
      rerr        <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], axistart};
      framedone <= 1'b0;

      // A late RLAST with nothing tracked (e.g. after a reset abort) is ignored.
      case ({ar_fire, r_done && (outst != 4'd0)})
        2'b10:   outst <= outst + 4'd1;
        2'b01:   outst <= outst - 4'd1;
        default: outst <= outst;
      endcase

      case (state)
        HALT: begin
          if (start) begin
            base   <= dispaddr;
            offset <= '0;
            rerr   <= 1'b0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end

        CHECK: begin
          if (!dispon || (offset == FRAME_OFS)) begin
            state <= DRAIN;
          end else if (space_ok) begin
            axi.arvalid <= 1'b1;
            axi.araddr  <= {2'b00, base + offset};
            state       <= ISSUE;
          end
        end

        // Once raised, ARVALID must stay up until accepted even if dispon drops.
        ISSUE: begin
          if (ar_fire) begin
            axi.arvalid <= 1'b0;
            offset      <= offset + BURST_OFS;
            state       <= CHECK;
          end
        end

        DRAIN: begin
          if (outst == 4'd0) begin
            busy      <= 1'b0;
            framedone <= (offset == FRAME_OFS);
            state     <= HALT;
          end
        end

        default: state <= HALT;
      endcase

      if (axi.rvalid && (axi.rresp != 2'b00)) begin
        rerr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_rdma_ctrl.sv
// Directed bench for disp_rdma_ctrl with a 2-burst frame
// (32 px x 2 lines x 4 B = 256 B, bursts of 16 x 8 B = 128 B).
module tb_disp_rdma_ctrl;

  logic        aclk;
  logic        arst;
  logic        axistart;
  logic        dispon;
  logic [29:0] dispaddr;
  logic [9:0]  fifofree;
  logic        busy;
  logic        framedone;
  logic        rerr;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;

  disp_rdma_ctrl_if bus ();

  disp_rdma_ctrl #(
    .H_RES(32), .V_RES(2), .BPP_BYTES(4), .DATA_BYTES(8),
    .BURST_BEATS(16), .MAX_OUTST(2), .FREE_W(10)
  ) dut (
    .aclk      (aclk),
    .arst      (arst),
    .axi       (bus.master),
    .axistart  (axistart),
    .dispon    (dispon),
    .dispaddr  (dispaddr),
    .fifofree  (fifofree),
    .busy      (busy),
    .framedone (framedone),
    .rerr      (rerr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(negedge aclk) if (framedone) fd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    axistart = 1'b1;
    tick();
    tick();
    axistart = 1'b0;
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    while (!bus.arvalid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.arvalid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic ar_accept();
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
  endtask

  // 16-beat read burst; bad_beat gets RRESP=2 (-1 for none);
  // ar_on_last raises ARREADY together with the RLAST beat.
  task automatic r_burst(input int bad_beat, input bit ar_on_last);
    for (int i = 0; i < 16; i++) begin
      bus.rvalid = 1'b1;
      bus.rlast  = (i == 15);
      bus.rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      if (ar_on_last && i == 15) bus.arready = 1'b1;
      tick();
    end
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rresp   = 2'b00;
    bus.arready = 1'b0;
  endtask

  initial begin
    bit stable;
    bit seen;

    arst        = 1'b1;
    axistart    = 1'b0;
    dispon      = 1'b1;
    dispaddr    = 30'h100;
    fifofree    = 10'd64;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rresp   = 2'b00;
    repeat (3) tick();
    arst = 1'b0;
    tick();

    // reset state
    chk("rst_arvalid",   32'(bus.arvalid), 32'd0);
    chk("rst_araddr",    bus.araddr,       32'd0);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_framedone", 32'(framedone),   32'd0);
    chk("rst_rerr",      32'(rerr),        32'd0);
    chk("rst_rready",    32'(bus.rready),  32'd0);

    // T1: plain 2-burst frame
    pulse_start();
    wait_ar("t1_ar0_valid");
    chk("t1_ar0_addr", bus.araddr, 32'h100);
    chk("t1_arlen",    32'(bus.arlen), 32'd15);
    chk("t1_busy",     32'(busy), 32'd1);
    ar_accept();
    chk("t1_ar0_drop", 32'(bus.arvalid), 32'd0);
    wait_ar("t1_ar1_valid");
    chk("t1_ar1_addr", bus.araddr, 32'h180);
    ar_accept();
    bus.rvalid = 1'b1;
    #1;
    chk("t1_rready", 32'(bus.rready), 32'd1);
    bus.rvalid = 1'b0;
    r_burst(-1, 1'b0);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    r_burst(-1, 1'b0);
    wait_idle("t1_idle");
    repeat (3) tick();
    chk("t1_framedone_cnt", 32'(fd_cnt), 32'd1);
    chk("t1_rerr", 32'(rerr), 32'd0);

    // T2: address backpressure
    dispaddr = 30'h1000;
    pulse_start();
    wait_ar("t2_ar0_valid");
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!bus.arvalid || bus.araddr != 32'h1000) stable = 1'b0;
      tick();
    end
    if (!bus.arvalid || bus.araddr != 32'h1000) stable = 1'b0;
    chk("t2_stable", 32'(stable), 32'd1);
    ar_accept();
    wait_ar("t2_ar1_valid");
    chk("t2_ar1_addr", bus.araddr, 32'h1080);
    ar_accept();
    r_burst(-1, 1'b0);
    r_burst(-1, 1'b0);
    wait_idle("t2_idle");
    repeat (2) tick();
    chk("t2_framedone_cnt", 32'(fd_cnt), 32'd2);

    // T3: FIFO space gate (16 fits in 20, 32 does not)
    dispaddr = 30'h200;
    fifofree = 10'd20;
    pulse_start();
    wait_ar("t3_ar0_valid");
    chk("t3_ar0_addr", bus.araddr, 32'h200);
    ar_accept();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.arvalid) seen = 1'b1;
      tick();
    end
    chk("t3_gated", 32'(seen), 32'd0);
    fifofree = 10'd32;
    wait_ar("t3_ar1_valid");
    chk("t3_ar1_addr", bus.araddr, 32'h280);
    ar_accept();
    r_burst(-1, 1'b0);
    r_burst(-1, 1'b0);
    wait_idle("t3_idle");
    repeat (2) tick();
    chk("t3_framedone_cnt", 32'(fd_cnt), 32'd3);
    fifofree = 10'd64;

    // T4: abort via dispon after the first address handshake
    dispaddr = 30'h300;
    pulse_start();
    wait_ar("t4_ar0_valid");
    ar_accept();
    dispon = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.arvalid) seen = 1'b1;
      tick();
    end
    chk("t4_no_ar1", 32'(seen), 32'd0);
    chk("t4_busy_drain", 32'(busy), 32'd1);
    r_burst(-1, 1'b0);
    wait_idle("t4_idle");
    repeat (3) tick();
    chk("t4_no_framedone", 32'(fd_cnt), 32'd3);
    dispon = 1'b1;
    tick();

    // T5: AR handshake coincides with RLAST; error response
    dispaddr = 30'h400;
    pulse_start();
    wait_ar("t5_ar0_valid");
    chk("t5_ar0_addr", bus.araddr, 32'h400);
    ar_accept();
    wait_ar("t5_ar1_valid");
    chk("t5_ar1_addr", bus.araddr, 32'h480);
    r_burst(3, 1'b1);
    chk("t5_ar1_drop", 32'(bus.arvalid), 32'd0);
    chk("t5_rerr_set", 32'(rerr), 32'd1);
    repeat (8) tick();
    chk("t5_still_busy", 32'(busy), 32'd1);
    r_burst(-1, 1'b0);
    wait_idle("t5_idle");
    repeat (2) tick();
    chk("t5_framedone_cnt", 32'(fd_cnt), 32'd4);
    chk("t5_rerr_sticky", 32'(rerr), 32'd1);

    // T6: reset mid-frame, then a start while busy is ignored
    dispaddr = 30'h2000;
    pulse_start();
    wait_ar("t6_ar0_valid");
    chk("t6_rerr_cleared", 32'(rerr), 32'd0);
    chk("t6_ar0_addr", bus.araddr, 32'h2000);
    ar_accept();
    wait_ar("t6_ar1_valid");
    arst = 1'b1;
    tick();
    chk("t6_rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("t6_rst_busy",    32'(busy),        32'd0);
    chk("t6_rst_araddr",  bus.araddr,       32'd0);
    arst = 1'b0;
    tick();

    pulse_start();
    wait_ar("t6b_ar0_valid");
    chk("t6b_ar0_addr", bus.araddr, 32'h2000);
    ar_accept();
    dispaddr = 30'h3000;
    pulse_start();
    repeat (5) tick();
    wait_ar("t6b_ar1_valid");
    chk("t6b_ar1_addr", bus.araddr, 32'h2080);
    ar_accept();
    r_burst(-1, 1'b0);
    r_burst(-1, 1'b0);
    wait_idle("t6b_idle");
    repeat (10) tick();
    chk("t6b_stays_idle", 32'(busy), 32'd0);
    chk("t6b_framedone_cnt", 32'(fd_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
